reg_writeback_file: RTL and testbench



---
 rtl/reg_writeback_file_pkg.sv | 14 +
 rtl/reg_writeback_file_scoreboard.sv | 90 +++++++++
 rtl/reg_writeback_file.sv | 91 +++++++++
 tb/tb_reg_writeback_file.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_writeback_file_pkg.sv
// Shared sizing defaults, null-register code and code range check for the write-back register file.
package reg_writeback_file_pkg;

  localparam int NUM_REGS_DEF = 32;
  localparam int DATA_W_DEF   = 32;
  localparam int CODE_W_DEF   = 8;
  localparam int NULL_REG     = 0;

  // Codes are zero-extended to 32 bits so this works for any CODE_W up to 32.
  function automatic logic code_in_range(input logic [31:0] code, input int num_regs);
    return code < 32'(num_regs);
  endfunction

endpackage

// File: rtl/reg_writeback_file_scoreboard.sv
// Busy scoreboard: per-register reservations, issue accept, pending count, sticky write-back error.
// Latency: accept is combinational, state updates at the next edge; backpressure: accept=0 stalls dispatch.
module reg_scoreboard
  import reg_writeback_file_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int CODE_W   = CODE_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wb_vld,
  input  logic [CODE_W-1:0]   wb_code,
  input  logic                issue_vld,
  input  logic [CODE_W-1:0]   issue_code,
  output logic                issue_accept,
  output logic                wb_hit,
  output logic [NUM_REGS-1:0] busy,
  output logic [CODE_W-1:0]   pending_count,
  output logic                wb_error
);

  logic [NUM_REGS-1:0] busy_q, busy_nxt;
  logic [CODE_W-1:0]   pending_q, pending_nxt;
  logic                wb_error_q;

  logic wb_in_range, wb_null, wb_busy;
  logic issue_in_range, issue_null, issue_busy;
  logic issue_set, wb_release, wb_bad;

  assign wb_in_range    = code_in_range(32'(wb_code), NUM_REGS);
  assign wb_null        = (wb_code == CODE_W'(NULL_REG));
  assign issue_in_range = code_in_range(32'(issue_code), NUM_REGS);
  assign issue_null     = (issue_code == CODE_W'(NULL_REG));

  // A write-back that actually lands in the file; the bypass and the busy clear both key off this.
  assign wb_hit = wb_vld & wb_in_range & ~wb_null;

  always_comb begin
    wb_busy    = 1'b0;
    issue_busy = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wb_code == CODE_W'(i))    wb_busy    = busy_q[i];
      if (issue_code == CODE_W'(i)) issue_busy = busy_q[i];
    end
  end

  // A same-cycle write-back to the requested code frees it, so the WAW stall is lifted early.
  assign issue_accept = issue_vld & rst_n & issue_in_range &
                        (issue_null | ~issue_busy | (wb_hit & (wb_code == issue_code)));

  assign issue_set  = issue_accept & ~issue_null;
  assign wb_release = wb_hit & wb_busy;
  assign wb_bad     = wb_vld & (~wb_in_range | (~wb_null & ~wb_busy));

  // Clear first, then set, so a new reservation on the same code wins.
  always_comb begin
    busy_nxt = busy_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wb_hit & (wb_code == CODE_W'(i)))       busy_nxt[i] = 1'b0;
      if (issue_set & (issue_code == CODE_W'(i))) busy_nxt[i] = 1'b1;
    end
    busy_nxt[NULL_REG] = 1'b0;
  end

  always_comb begin
    pending_nxt = pending_q;
    case ({issue_set, wb_release})
      2'b10:   pending_nxt = pending_q + CODE_W'(1);
      2'b01:   pending_nxt = pending_q - CODE_W'(1);
      default: pending_nxt = pending_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      pending_q  <= '0;
      wb_error_q <= 1'b0;
    end else begin
      busy_q     <= busy_nxt;
      pending_q  <= pending_nxt;
      wb_error_q <= wb_error_q | wb_bad;
    end
  end

  assign busy          = busy_q;
  assign pending_count = pending_q;
  assign wb_error      = wb_error_q;

endmodule

// File: rtl/reg_writeback_file.sv
// Architectural register file fed by the write-back bus, two combinational read ports with bypass.
// Latency: result-to-operand 0 cycles via bypass; backpressure: none on write-back, issue stalls on WAW.
module reg_writeback_file
  import reg_writeback_file_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int CODE_W   = CODE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              REG_write_back_flag,
  input  logic [CODE_W-1:0] REG_write_back_code,
  input  logic [DATA_W-1:0] REG_write_back_data,
  input  logic              ISSUE_valid,
  input  logic [CODE_W-1:0] ISSUE_code,
  output logic              ISSUE_accept,
  input  logic [CODE_W-1:0] RD_A_code,
  output logic [DATA_W-1:0] RD_A_data,
  output logic              RD_A_busy,
  input  logic [CODE_W-1:0] RD_B_code,
  output logic [DATA_W-1:0] RD_B_data,
  output logic              RD_B_busy,
  output logic [CODE_W-1:0] PENDING_count,
  output logic              WB_error
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic                wb_hit;

  logic [CODE_W-1:0] rd_code [2];
  logic [DATA_W-1:0] rd_dat  [2];
  logic              rd_busy [2];

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .CODE_W   (CODE_W)
  ) u_scoreboard (
    .clk           (clk),
    .rst_n         (rst_n),
    .wb_vld        (REG_write_back_flag),
    .wb_code       (REG_write_back_code),
    .issue_vld     (ISSUE_valid),
    .issue_code    (ISSUE_code),
    .issue_accept  (ISSUE_accept),
    .wb_hit        (wb_hit),
    .busy          (busy),
    .pending_count (PENDING_count),
    .wb_error      (WB_error)
  );

  // Unreserved write-backs still store data; only the null register and out-of-range codes are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wb_hit && (REG_write_back_code == CODE_W'(i))) regs_q[i] <= REG_write_back_data;
      end
    end
  end

  assign rd_code[0] = RD_A_code;
  assign rd_code[1] = RD_B_code;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    always_comb begin
      rd_dat[p]  = '0;
      rd_busy[p] = 1'b0;
      if (code_in_range(32'(rd_code[p]), NUM_REGS) && (rd_code[p] != CODE_W'(NULL_REG))) begin
        if (wb_hit && (REG_write_back_code == rd_code[p])) begin
          rd_dat[p] = REG_write_back_data;
        end else begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_code[p] == CODE_W'(i)) begin
              rd_dat[p]  = regs_q[i];
              rd_busy[p] = busy[i];
            end
          end
        end
      end
    end
  end

  assign RD_A_data = rd_dat[0];
  assign RD_A_busy = rd_busy[0];
  assign RD_B_data = rd_dat[1];
  assign RD_B_busy = rd_busy[1];

endmodule

// File: tb/tb_reg_writeback_file.sv
// Vector table plus model-driven random traffic for reg_writeback_file, checked through an expectation queue.
module tb_reg_writeback_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_flag;
  logic [7:0]  wb_code;
  logic [31:0] wb_data;
  logic        issue_valid;
  logic [7:0]  issue_code;
  logic        issue_accept;
  logic [7:0]  rd_a_code, rd_b_code;
  logic [31:0] rd_a_data, rd_b_data;
  logic        rd_a_busy, rd_b_busy;
  logic [7:0]  pending_count;
  logic        wb_error;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reg_writeback_file #(.NUM_REGS(32), .DATA_W(32), .CODE_W(8)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .REG_write_back_flag (wb_flag),
    .REG_write_back_code (wb_code),
    .REG_write_back_data (wb_data),
    .ISSUE_valid         (issue_valid),
    .ISSUE_code          (issue_code),
    .ISSUE_accept        (issue_accept),
    .RD_A_code           (rd_a_code),
    .RD_A_data           (rd_a_data),
    .RD_A_busy           (rd_a_busy),
    .RD_B_code           (rd_b_code),
    .RD_B_data           (rd_b_data),
    .RD_B_busy           (rd_b_busy),
    .PENDING_count       (pending_count),
    .WB_error            (wb_error)
  );

  typedef struct {
    logic        rst_n;
    logic        wbf;
    logic [7:0]  wbc;
    logic [31:0] wbd;
    logic        iv;
    logic [7:0]  ic;
    logic [7:0]  ac;
    logic [7:0]  bc;
    logic [31:0] ad;
    logic        ab;
    logic [31:0] bd;
    logic        bb;
    logic        acc;
    logic [7:0]  pend;
    logic        err;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[21];

  // Reference state for the random phase.
  logic [31:0] m_regs [32];
  logic        m_busy [32];
  int          m_pend;
  logic        m_err;

  function automatic vec_t mk(logic r, logic wbf, logic [7:0] wbc, logic [31:0] wbd,
                              logic iv, logic [7:0] ic, logic [7:0] ac, logic [7:0] bc,
                              logic [31:0] ad, logic ab, logic [31:0] bd, logic bb,
                              logic acc, logic [7:0] pend, logic err);
    vec_t v;
    v.rst_n = r;  v.wbf = wbf; v.wbc = wbc; v.wbd = wbd;
    v.iv = iv;    v.ic = ic;   v.ac = ac;   v.bc = bc;
    v.ad = ad;    v.ab = ab;   v.bd = bd;   v.bb = bb;
    v.acc = acc;  v.pend = pend; v.err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input vec_t e, input string tag);
    check({tag, " rd_a_data"}, rd_a_data, e.ad);
    check({tag, " rd_a_busy"}, 32'(rd_a_busy), 32'(e.ab));
    check({tag, " rd_b_data"}, rd_b_data, e.bd);
    check({tag, " rd_b_busy"}, 32'(rd_b_busy), 32'(e.bb));
    check({tag, " accept"},    32'(issue_accept), 32'(e.acc));
    check({tag, " pending"},   32'(pending_count), 32'(e.pend));
    check({tag, " wb_error"},  32'(wb_error), 32'(e.err));
  endtask

  task automatic drive(input vec_t v);
    rst_n       = v.rst_n;
    wb_flag     = v.wbf;
    wb_code     = v.wbc;
    wb_data     = v.wbd;
    issue_valid = v.iv;
    issue_code  = v.ic;
    rd_a_code   = v.ac;
    rd_b_code   = v.bc;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    vec_t e;
    @(posedge clk);
    #1;
    drive(v);
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    check_outputs(e, tag);
  endtask

  task automatic model_read(input logic [7:0] c, input vec_t v, output logic [31:0] d, output logic b);
    d = '0;
    b = 1'b0;
    if (c != 0 && c < 32) begin
      if (v.wbf && v.wbc == c) d = v.wbd;
      else begin
        d = m_regs[c[4:0]];
        b = m_busy[c[4:0]];
      end
    end
  endtask

  task automatic model_expect(inout vec_t v);
    logic hit;
    hit = v.wbf && v.wbc != 0 && v.wbc < 32;
    model_read(v.ac, v, v.ad, v.ab);
    model_read(v.bc, v, v.bd, v.bb);
    v.acc  = v.iv && v.ic < 32 &&
             (v.ic == 0 || !m_busy[v.ic[4:0]] || (hit && v.wbc == v.ic));
    v.pend = 8'(m_pend);
    v.err  = m_err;
  endtask

  task automatic model_update(input vec_t v);
    if (v.wbf) begin
      if (v.wbc >= 32) m_err = 1'b1;
      else if (v.wbc != 0) begin
        if (!m_busy[v.wbc[4:0]]) m_err = 1'b1;
        else begin
          m_busy[v.wbc[4:0]] = 1'b0;
          m_pend--;
        end
        m_regs[v.wbc[4:0]] = v.wbd;
      end
    end
    if (v.acc && v.ic != 0) begin
      m_busy[v.ic[4:0]] = 1'b1;
      m_pend++;
    end
  endtask

  initial begin
    vec_t v;
    logic found;
    int   start;
    int   r;

    rst_n = 1'b0; wb_flag = 1'b0; wb_code = '0; wb_data = '0;
    issue_valid = 1'b0; issue_code = '0; rd_a_code = '0; rd_b_code = '0;

    //            rst wbf wbc    wbd            iv ic     ac     bc      ad             ab bd             bb acc pend err
    tbl[0]  = mk(0, 0, 8'd0,  32'h0,         1, 8'd3,  8'd3,  8'd0,  32'h0,         0, 32'h0,         0, 0, 8'd0, 0);
    tbl[1]  = mk(1, 0, 8'd0,  32'h0,         1, 8'd5,  8'd5,  8'd3,  32'h0,         0, 32'h0,         0, 1, 8'd0, 0);
    tbl[2]  = mk(1, 0, 8'd0,  32'h0,         0, 8'd0,  8'd5,  8'd0,  32'h0,         1, 32'h0,         0, 0, 8'd1, 0);
    tbl[3]  = mk(1, 1, 8'd5,  32'hDEADBEEF,  0, 8'd0,  8'd5,  8'd5,  32'hDEADBEEF,  0, 32'hDEADBEEF,  0, 0, 8'd1, 0);
    tbl[4]  = mk(1, 0, 8'd0,  32'h0,         0, 8'd0,  8'd5,  8'd7,  32'hDEADBEEF,  0, 32'h0,         0, 0, 8'd0, 0);
    tbl[5]  = mk(1, 0, 8'd0,  32'h0,         1, 8'd7,  8'd7,  8'd5,  32'h0,         0, 32'hDEADBEEF,  0, 1, 8'd0, 0);
    tbl[6]  = mk(1, 0, 8'd0,  32'h0,         1, 8'd7,  8'd7,  8'd5,  32'h0,         1, 32'hDEADBEEF,  0, 0, 8'd1, 0);
    tbl[7]  = mk(1, 1, 8'd7,  32'h77,        1, 8'd7,  8'd7,  8'd5,  32'h77,        0, 32'hDEADBEEF,  0, 1, 8'd1, 0);
    tbl[8]  = mk(1, 0, 8'd0,  32'h0,         0, 8'd0,  8'd7,  8'd0,  32'h77,        1, 32'h0,         0, 0, 8'd1, 0);
    tbl[9]  = mk(1, 1, 8'd7,  32'h78,        0, 8'd0,  8'd7,  8'd7,  32'h78,        0, 32'h78,        0, 0, 8'd1, 0);
    tbl[10] = mk(1, 0, 8'd0,  32'h0,         1, 8'd0,  8'd0,  8'd7,  32'h0,         0, 32'h78,        0, 1, 8'd0, 0);
    tbl[11] = mk(1, 1, 8'd0,  32'h1234,      0, 8'd0,  8'd0,  8'd5,  32'h0,         0, 32'hDEADBEEF,  0, 0, 8'd0, 0);
    tbl[12] = mk(1, 0, 8'd0,  32'h0,         0, 8'd0,  8'd0,  8'd9,  32'h0,         0, 32'h0,         0, 0, 8'd0, 0);
    tbl[13] = mk(1, 1, 8'd9,  32'h9,         0, 8'd0,  8'd9,  8'd7,  32'h9,         0, 32'h78,        0, 0, 8'd0, 0);
    tbl[14] = mk(1, 1, 8'd40, 32'hAA,        0, 8'd0,  8'd9,  8'd40, 32'h9,         0, 32'h0,         0, 0, 8'd0, 1);
    tbl[15] = mk(1, 0, 8'd0,  32'h0,         1, 8'd40, 8'd40, 8'd9,  32'h0,         0, 32'h9,         0, 0, 8'd0, 1);
    tbl[16] = mk(1, 0, 8'd0,  32'h0,         1, 8'd3,  8'd3,  8'd9,  32'h0,         0, 32'h9,         0, 1, 8'd0, 1);
    tbl[17] = mk(1, 1, 8'd3,  32'h33,        1, 8'd4,  8'd3,  8'd4,  32'h33,        0, 32'h0,         0, 1, 8'd1, 1);
    tbl[18] = mk(1, 0, 8'd0,  32'h0,         1, 8'd10, 8'd3,  8'd4,  32'h33,        0, 32'h0,         1, 1, 8'd1, 1);
    tbl[19] = mk(1, 0, 8'd0,  32'h0,         1, 8'd11, 8'd10, 8'd4,  32'h0,         1, 32'h0,         1, 1, 8'd2, 1);
    tbl[20] = mk(1, 0, 8'd0,  32'h0,         0, 8'd0,  8'd3,  8'd10, 32'h33,        0, 32'h0,         1, 0, 8'd3, 1);

    for (int i = 0; i < 21; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of a cycle with three registers reserved.
    #2;
    issue_valid = 1'b1;
    issue_code  = 8'd12;
    #1;
    check("pre_rst accept", 32'(issue_accept), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst rd_a_data", rd_a_data, 32'h0);
    check("async_rst rd_b_busy", 32'(rd_b_busy), 32'd0);
    check("async_rst pending",   32'(pending_count), 32'd0);
    check("async_rst wb_error",  32'(wb_error), 32'd0);
    check("async_rst accept",    32'(issue_accept), 32'd0);
    @(negedge clk);
    run_vec(mk(1, 0, 8'd0, 32'h0, 0, 8'd0, 8'd4, 8'd3, 32'h0, 0, 32'h0, 0, 0, 8'd0, 0), "post_rst");

    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_pend = 0;
    m_err  = 1'b0;

    for (int n = 0; n < 300; n++) begin
      v.rst_n = 1'b1;
      v.wbf   = 1'($urandom_range(0, 1));
      v.wbd   = $urandom;
      v.wbc   = 8'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) v.wbc = 8'($urandom_range(0, 39));
      else begin
        found = 1'b0;
        start = int'($urandom_range(0, 31));
        for (int k = 0; k < 32; k++) begin
          r = (start + k) % 32;
          if (m_busy[r] && !found) begin
            v.wbc = 8'(r);
            found = 1'b1;
          end
        end
      end
      v.iv = 1'($urandom_range(0, 1));
      v.ic = 8'($urandom_range(0, 35));
      v.ac = 8'($urandom_range(0, 35));
      v.bc = 8'($urandom_range(0, 35));
      if ($urandom_range(0, 3) == 0) v.ac = v.wbc;
      model_expect(v);
      run_vec(v, $sformatf("rnd%0d", n));
      model_update(v);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
